keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronises and debounces it, and produces the controller's front-panel inputs.
- Outputs are a one-hot 10-bit digit bus and active-low START/STOP/CLEAR levels.
- Sits directly upstream of the oven controller. Its keypad, startn, stopn and clearn outputs drive the controller's same-named inputs.

Parameters:
- SCAN_DIV, 4: clk cycles each row is driven. Legal range is 3 or more, to cover synchroniser plus settling.
- DEBOUNCE_FRAMES, 3: consecutive identical full-matrix frames required before the stable key changes. Legal range is 1 to 255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- col_n  in  4  matrix column returns; asynchronous; active-low, pulled up externally.
- row_n  out  4  matrix row drive; one-hot-low; exactly one bit low at all times.
- keypad  out  10  one-hot; bit n high while digit n is stably pressed.
- startn  out  1  low while START is stably pressed.
- stopn  out  1  low while STOP is stably pressed.
- clearn  out  1  low while CLEAR is stably pressed.
- key_valid  out  1  high while any mapped key is stable.
- key_event  out  1  one-cycle pulse when the stable key changes to a new mapped key.

Behaviour:
- Reset (resetn low at an edge):
  - row_n = 4'b1110; slot counter = 0; row index = 0; partial frame map cleared; debounce candidate = NONE; count = 0; stable = NONE.
  - keypad = 0; startn = stopn = clearn = 1; key_valid = 0; key_event = 0.
  - Reset mid-frame discards the partial frame; scanning restarts at row 0.
- Synchroniser: col_n passes through two flops before use. Raw col_n is never sampled directly.
- Row FSM (states ROW0 to ROW3):
  - Each state lasts SCAN_DIV cycles with row_n[r] low.
  - On the last cycle of the slot, the inverted synchronised columns are written into map[4r+3:4r].
  - Transitions: ROW3 goes to ROW0. One frame = 4*SCAN_DIV cycles.
- Key map (row, col):
  - (0,0)=1, (0,1)=2, (0,2)=3, (0,3)=START
  - (1,0)=4, (1,1)=5, (1,2)=6, (1,3)=STOP
  - (2,0)=7, (2,1)=8, (2,2)=9, (2,3)=CLEAR
  - (3,1)=0
  - (3,0), (3,2), (3,3) are unmapped.
- Frame code, evaluated at frame end (last cycle of ROW3):
  - Zero keys in map gives NONE.
  - Exactly one key gives that key's position code, unmapped positions included.
  - Two or more keys give NONE (ghost/multi-press rejection).
- Debounce, at frame end:
  - If code == candidate, count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise candidate <= code and count <= 1.
  - When the updated count equals DEBOUNCE_FRAMES and candidate != stable, stable <= candidate.
- Outputs:
  - Registered and decoded from stable; they change on the cycle after the frame-end edge that updates stable.
  - An unmapped stable code drives all outputs inactive (same as NONE), including key_valid = 0.
- key_event:
  - High for exactly one cycle, coincident with the output update, when the new stable value is a mapped key.
  - No pulse on release to NONE, or on a change to an unmapped key.
- Direct key change A to B with no release between: outputs switch from A to B in one update, and key_event pulses.
- Latency: for a press stable from before frame k's sampling, outputs update one cycle after the end of frame k+DEBOUNCE_FRAMES-1. Release behaves the same way.
- Invariants:
  - At most one of the 10 keypad bits, or the three active-low controls, is active at a time.
  - row_n is always one-hot-low.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 cycles):
- Reset then idle, col_n = 4'hF:
  - row_n cycles 1110, 1101, 1011, 0111, each held 4 cycles.
  - keypad = 0, startn/stopn/clearn = 1, key_valid = 0, no key_event, for 10 frames.
- Hold key 5 (row 1, col 1) for 5 frames:
  - keypad = 10'b0000100000 one cycle after the 3rd frame end; key_event pulses once.
  - After release, keypad returns to 0 after 3 further frame ends; no key_event on release.
- Bounce: key 7 toggles every 10 cycles for 4 frames, then is held:
  - No output change during bouncing.
  - keypad[7] = 1 only after 3 clean consecutive frames.
- Hold START and key 2 together:
  - Frame code is NONE; outputs stay inactive; startn = 1.
  - Releasing key 2 gives startn = 0 three frames later.
- Press STOP, then CLEAR, then 0 in sequence, each held 4 frames with no gap:
  - stopn = 0, then clearn = 0 with stopn = 1, then keypad[0] = 1.
  - key_event pulses 3 times.
- Hold key 9 for 3 frames; assert resetn low mid-frame, then release:
  - Outputs return immediately to reset values; row_n = 1110.
  - keypad[9] reasserts only after 3 full new frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row drive, column synchroniser, frame capture,
// single-key frame coding with multi-press rejection, frame-count debounce and decoded outputs.
module keypad_scanner #(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_FRAMES = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [9:0] keypad,
   output logic       startn,
   output logic       stopn,
   output logic       clearn,
   output logic       key_valid,
   output logic       key_event
);

   localparam int            SW        = $clog2(SCAN_DIV);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [7:0]    DB_MAX    = 8'(DEBOUNCE_FRAMES);
   localparam logic [4:0]    CODE_NONE = 5'd16;

   typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_e;

   logic [3:0]    sync1_q, sync2_q;
   logic [SW-1:0] slot_q, slot_d;
   row_e          row_q, row_d;
   logic [3:0]    row_n_q, row_n_d;
   logic [15:0]   map_q, map_d;
   logic [4:0]    cand_q, cand_d, stable_q, stable_d, shown_q;
   logic [7:0]    cnt_q, cnt_d;
   logic [9:0]    keypad_q, keypad_d;
   logic          startn_q, startn_d, stopn_q, stopn_d, clearn_q, clearn_d;
   logic          key_valid_q, key_valid_d, key_event_q, key_event_d;

   logic          slot_last, frame_end;
   logic [4:0]    nkeys, code;
   logic [3:0]    pos;

   always_comb begin
      slot_last = (slot_q == SLOT_LAST);
      frame_end = slot_last && (row_q == ROW3);
      slot_d    = slot_last ? '0 : slot_q + SW'(1);
      row_d     = slot_last ? row_e'(row_q + 2'd1) : row_q;
      case (row_d)
         ROW0:    row_n_d = 4'b1110;
         ROW1:    row_n_d = 4'b1101;
         ROW2:    row_n_d = 4'b1011;
         default: row_n_d = 4'b0111;
      endcase

      // The frame code must see row 3's columns, which land in the map on this same edge.
      map_d = map_q;
      if (slot_last) map_d[{row_q, 2'b00} +: 4] = ~sync2_q;

      nkeys = '0;
      pos   = '0;
      for (int i = 0; i < 16; i++) begin
         if (map_d[i]) begin
            nkeys = nkeys + 5'd1;
            pos   = 4'(i);
         end
      end
      code = (nkeys == 5'd1) ? {1'b0, pos} : CODE_NONE;

      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (frame_end) begin
         if (code == cand_q) begin
            cnt_d = (cnt_q == DB_MAX) ? cnt_q : cnt_q + 8'd1;
         end else begin
            cand_d = code;
            cnt_d  = 8'd1;
         end
         if (cnt_d == DB_MAX && cand_d != stable_q) stable_d = cand_d;
      end

      keypad_d = '0;
      startn_d = 1'b1;
      stopn_d  = 1'b1;
      clearn_d = 1'b1;
      case (stable_q)
         5'd0:    keypad_d[1] = 1'b1;
         5'd1:    keypad_d[2] = 1'b1;
         5'd2:    keypad_d[3] = 1'b1;
         5'd3:    startn_d    = 1'b0;
         5'd4:    keypad_d[4] = 1'b1;
         5'd5:    keypad_d[5] = 1'b1;
         5'd6:    keypad_d[6] = 1'b1;
         5'd7:    stopn_d     = 1'b0;
         5'd8:    keypad_d[7] = 1'b1;
         5'd9:    keypad_d[8] = 1'b1;
         5'd10:   keypad_d[9] = 1'b1;
         5'd11:   clearn_d    = 1'b0;
         5'd13:   keypad_d[0] = 1'b1;
         default: ;
      endcase
      key_valid_d = (|keypad_d) | ~startn_d | ~stopn_d | ~clearn_d;
      key_event_d = key_valid_d && (stable_q != shown_q);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q     <= 4'hF;
         sync2_q     <= 4'hF;
         slot_q      <= '0;
         row_q       <= ROW0;
         row_n_q     <= 4'b1110;
         map_q       <= '0;
         cand_q      <= CODE_NONE;
         cnt_q       <= '0;
         stable_q    <= CODE_NONE;
         shown_q     <= CODE_NONE;
         keypad_q    <= '0;
         startn_q    <= 1'b1;
         stopn_q     <= 1'b1;
         clearn_q    <= 1'b1;
         key_valid_q <= 1'b0;
         key_event_q <= 1'b0;
      end else begin
         sync1_q     <= col_n;
         sync2_q     <= sync1_q;
         slot_q      <= slot_d;
         row_q       <= row_d;
         row_n_q     <= row_n_d;
         map_q       <= map_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         stable_q    <= stable_d;
         shown_q     <= stable_q;
         keypad_q    <= keypad_d;
         startn_q    <= startn_d;
         stopn_q     <= stopn_d;
         clearn_q    <= clearn_d;
         key_valid_q <= key_valid_d;
         key_event_q <= key_event_d;
      end
   end

   assign row_n     = row_n_q;
   assign keypad    = keypad_q;
   assign startn    = startn_q;
   assign stopn     = stopn_q;
   assign clearn    = clearn_q;
   assign key_valid = key_valid_q;
   assign key_event = key_event_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural matrix model, frame-aligned vector table with a
// scoreboard queue, plus hand-timed bounce, direct-change and mid-frame reset sequences.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] col_n, row_n;
   logic [9:0] keypad;
   logic       startn, stopn, clearn, key_valid, key_event;
   logic [15:0] press = '0;
   int          cyc = 0;
   int          checks = 0, errors = 0;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
      .clk(clk), .resetn(resetn), .col_n(col_n), .row_n(row_n), .keypad(keypad),
      .startn(startn), .stopn(stopn), .clearn(clearn), .key_valid(key_valid),
      .key_event(key_event)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls column c low while row r is driven low.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[4*r+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   always_ff @(posedge clk) cyc <= resetn ? cyc + 1 : 0;

   logic [14:0] obs;
   assign obs = {keypad, startn, stopn, clearn, key_valid, key_event};

   localparam logic [15:0] K0 = 16'h2000, K2 = 16'h0002, K5 = 16'h0020, K7 = 16'h0100,
                           K9 = 16'h0400, KST = 16'h0008, KSP = 16'h0080, KCL = 16'h0800,
                           KU = 16'h1000;

   function automatic logic [14:0] ex(logic [9:0] kp, logic [2:0] ctl, logic v, logic e);
      return {kp, ctl, v, e};
   endfunction

   localparam logic [14:0] OFF = {10'h000, 3'b111, 1'b0, 1'b0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h at cyc %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      logic [3:0] er;
      @(negedge clk);
      er = ~(4'b0001 << ((cyc / 4) % 4));
      check("row_n", 32'(row_n), 32'(er));
      check("onehot", 32'($onehot0({keypad, ~startn, ~stopn, ~clearn})), 32'd1);
   endtask

   typedef struct {
      logic [15:0] mask;
      logic [14:0] exp;
   } vec_t;
   vec_t vecs[$];
   logic [14:0] sbq[$];

   task automatic add(input int n, input logic [15:0] m, input logic [14:0] e);
      vec_t v;
      v.mask = m;
      v.exp  = e;
      repeat (n) vecs.push_back(v);
   endtask

   initial begin
      logic [14:0] cur;
      logic        bad;

      add(10, '0,        OFF);
      add(2,  K5,        OFF);
      add(1,  K5,        ex(10'h020, 3'b111, 1, 1));
      add(2,  K5,        ex(10'h020, 3'b111, 1, 0));
      add(2,  '0,        ex(10'h020, 3'b111, 1, 0));
      add(1,  '0,        OFF);
      add(4,  KST | K2,  OFF);
      add(2,  KST,       OFF);
      add(1,  KST,       ex(10'h000, 3'b011, 1, 1));
      add(2,  KSP,       ex(10'h000, 3'b011, 1, 0));
      add(1,  KSP,       ex(10'h000, 3'b101, 1, 1));
      add(1,  KSP,       ex(10'h000, 3'b101, 1, 0));
      add(2,  KCL,       ex(10'h000, 3'b101, 1, 0));
      add(1,  KCL,       ex(10'h000, 3'b110, 1, 1));
      add(1,  KCL,       ex(10'h000, 3'b110, 1, 0));
      add(2,  K0,        ex(10'h000, 3'b110, 1, 0));
      add(1,  K0,        ex(10'h001, 3'b111, 1, 1));
      add(1,  K0,        ex(10'h001, 3'b111, 1, 0));
      add(2,  KU,        ex(10'h001, 3'b111, 1, 0));
      add(2,  KU,        OFF);
      add(3,  '0,        OFF);

      resetn = 1'b0;
      tick();
      tick();
      check("reset_outputs", 32'(obs), 32'(OFF));
      check("reset_row", 32'(row_n), 32'(4'b1110));
      resetn = 1'b1;
      cur = OFF;

      foreach (vecs[f]) begin
         check("hold_until_update", 32'(obs), 32'(cur));
         press = vecs[f].mask;
         sbq.push_back(vecs[f].exp);
         tick();
         if (f > 0) begin
            cur = sbq.pop_front();
            check($sformatf("frame_%0d", f - 1), 32'(obs), 32'(cur));
            cur[0] = 1'b0;
         end
         tick();
         check("event_width", 32'(key_event), 32'd0);
         repeat (14) tick();
      end
      check("hold_until_update", 32'(obs), 32'(cur));
      tick();
      cur = sbq.pop_front();
      check("frame_last", 32'(obs), 32'(cur));

      // Key 7 bounces with a 20-cycle period starting at frame cycle 8, then stays down.
      repeat (7) tick();
      bad = 1'b0;
      for (int t = 0; t < 89; t++) begin
         press = (t >= 64 || (t % 20) < 10) ? K7 : '0;
         if (obs !== OFF) bad = 1'b1;
         tick();
      end
      check("bounce_quiet", 32'(bad), 32'd0);
      check("bounce_settled", 32'(obs), 32'(ex(10'h080, 3'b111, 1, 1)));

      press = K9;
      repeat (47) tick();
      check("k7_held", 32'(obs), 32'(ex(10'h080, 3'b111, 1, 0)));
      tick();
      check("k7_to_k9", 32'(obs), 32'(ex(10'h200, 3'b111, 1, 1)));

      repeat (5) tick();
      resetn = 1'b0;
      tick();
      check("mid_reset_outputs", 32'(obs), 32'(OFF));
      check("mid_reset_row", 32'(row_n), 32'(4'b1110));
      resetn = 1'b1;
      repeat (48) tick();
      check("post_reset_wait", 32'(obs), 32'(OFF));
      tick();
      check("post_reset_k9", 32'(obs), 32'(ex(10'h200, 3'b111, 1, 1)));
      tick();
      check("post_reset_k9_hold", 32'(obs), 32'(ex(10'h200, 3'b111, 1, 0)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
